// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SHADOW
  } state_t;

  localparam int unsigned SHADOW_W        = 3;
  localparam logic [31:0] REDIRECT_PC_RST = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Branch/jump redirect sequencer: picks redirect PC, pulses flushes, masks the shadow window.
// Optional branch statistics are built only when BRANCH_STATS_EN is defined.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned SHADOW_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exe_valid,
  input  logic             exe_beq,
  input  logic             exe_bne,
  input  logic             exe_zero,
  input  logic [31:0]      exe_branch_addr,
  input  logic             id_valid,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_addr,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             busy,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken
);

  state_t              state;
  logic [SHADOW_W-1:0] shadow_cnt;
  logic                taken;
  logic                jump;

  // BEQ wins when both opcode flags are set.
  always_comb begin
    taken = 1'b0;
    if (exe_valid) begin
      if (exe_beq)      taken = exe_zero;
      else if (exe_bne) taken = ~exe_zero;
    end
  end

  assign jump = id_valid & id_jump;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      shadow_cnt     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= REDIRECT_PC_RST;
      flush_if_id    <= 1'b0;
      flush_id_exe   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      flush_if_id    <= 1'b0;
      flush_id_exe   <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            if (taken) begin
              state          <= REDIRECT;
              redirect_valid <= 1'b1;
              redirect_pc    <= exe_branch_addr;
              flush_if_id    <= 1'b1;
              flush_id_exe   <= 1'b1;
              shadow_cnt     <= SHADOW_W'(SHADOW_CYCLES);
              busy           <= 1'b1;
            end else if (jump) begin
              state          <= REDIRECT;
              redirect_valid <= 1'b1;
              redirect_pc    <= id_jump_addr;
              flush_if_id    <= 1'b1;
              shadow_cnt     <= SHADOW_W'(1);
              busy           <= 1'b1;
            end
          end
        end
        // Flush beats stall in the pipeline registers, so the pulse is never stretched.
        REDIRECT: begin
          state <= SHADOW;
          busy  <= 1'b1;
        end
        SHADOW: begin
          if (!stall) begin
            shadow_cnt <= shadow_cnt - 1'b1;
            if (shadow_cnt == SHADOW_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic br_event;
  logic tk_event;

  assign br_event = (state == IDLE) & ~stall & exe_valid & (exe_beq | exe_bne);
  assign tk_event = (state == IDLE) & ~stall & taken;

  sat_counter #(.W(CNT_W)) u_stat_branches (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_event),
    .count (stat_branches)
  );

  sat_counter #(.W(CNT_W)) u_stat_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tk_event),
    .count (stat_taken)
  );
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed table, saturation run, randomized model check.
module tb_pc_redirect_ctrl;

  localparam int unsigned SH  = 2;
  localparam int unsigned CW  = 4;
  localparam int          SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n, stall, exe_valid, exe_beq, exe_bne, exe_zero;
  logic [31:0]   exe_branch_addr, id_jump_addr;
  logic          id_valid, id_jump;
  logic          redirect_valid, flush_if_id, flush_id_exe, busy;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] stat_branches, stat_taken;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.SHADOW_CYCLES(SH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .exe_valid(exe_valid), .exe_beq(exe_beq), .exe_bne(exe_bne), .exe_zero(exe_zero),
    .exe_branch_addr(exe_branch_addr),
    .id_valid(id_valid), .id_jump(id_jump), .id_jump_addr(id_jump_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe), .busy(busy),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  typedef struct {
    logic rst_n, stall, ev, beq, bne, zero;
    logic [31:0] baddr;
    logic iv, jmp;
    logic [31:0] jaddr;
  } stim_t;

  typedef struct {
    stim_t s;
    logic rv;
    logic [31:0] pc;
    logic fif, fie, busy;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: a redirect pulse pending for the next cycle, then a count of
  // non-stalled cycles still to be ignored before resolutions are accepted again.
  int          m_pulse, m_wait, m_sb, m_st;
  logic [31:0] m_pc;
  logic        m_fif, m_fie;

  function automatic stim_t mk(logic r, logic st, logic ev, logic beq, logic bne, logic z,
                               logic [31:0] ba, logic iv, logic j, logic [31:0] ja);
    stim_t s;
    s.rst_n = r; s.stall = st; s.ev = ev; s.beq = beq; s.bne = bne; s.zero = z;
    s.baddr = ba; s.iv = iv; s.jmp = j; s.jaddr = ja;
    return s;
  endfunction

  function automatic vec_t row(stim_t s, logic rv, logic [31:0] pc, logic fif, logic fie, logic b);
    vec_t v;
    v.s = s; v.rv = rv; v.pc = pc; v.fif = fif; v.fie = fie; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input stim_t s);
    bit br, tk;
    if (!s.rst_n) begin
      m_pulse = 0; m_wait = 0; m_pc = '0; m_fif = 0; m_fie = 0; m_sb = 0; m_st = 0;
    end else if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (m_wait > 0) begin
      if (!s.stall) m_wait--;
    end else if (!s.stall) begin
      br = s.ev && (s.beq || s.bne);
      tk = s.ev && (s.beq ? s.zero : (s.bne && !s.zero));
      if (br && m_sb < SAT) m_sb++;
      if (tk && m_st < SAT) m_st++;
      if (tk) begin
        m_pulse = 1; m_wait = SH; m_pc = s.baddr; m_fif = 1; m_fie = 1;
      end else if (s.iv && s.jmp) begin
        m_pulse = 1; m_wait = 1; m_pc = s.jaddr; m_fif = 1; m_fie = 0;
      end
    end
  endtask

  task automatic model_check();
    chk("m_redirect_valid", 32'(redirect_valid), 32'(m_pulse != 0));
    chk("m_redirect_pc", redirect_pc, m_pc);
    chk("m_flush_if_id", 32'(flush_if_id), 32'((m_pulse != 0) && m_fif));
    chk("m_flush_id_exe", 32'(flush_id_exe), 32'((m_pulse != 0) && m_fie));
    chk("m_busy", 32'(busy), 32'((m_pulse != 0) || (m_wait > 0)));
`ifdef BRANCH_STATS_EN
    chk("m_stat_branches", 32'(stat_branches), 32'(m_sb));
    chk("m_stat_taken", 32'(stat_taken), 32'(m_st));
`else
    chk("m_stat_branches", 32'(stat_branches), 32'd0);
    chk("m_stat_taken", 32'(stat_taken), 32'd0);
`endif
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    rst_n = s.rst_n; stall = s.stall; exe_valid = s.ev; exe_beq = s.beq; exe_bne = s.bne;
    exe_zero = s.zero; exe_branch_addr = s.baddr; id_valid = s.iv; id_jump = s.jmp;
    id_jump_addr = s.jaddr;
    @(posedge clk);
    model_edge(s);
    #1;
    model_check();
  endtask

  vec_t  tbl[$];
  stim_t idle_s, beq40, bne_nt, j100, beq80j, j200, beq44, beq44s, beq84r, beq48s, beq48;
  stim_t rs;

  initial begin
    {rst_n, stall, exe_valid, exe_beq, exe_bne, exe_zero, id_valid, id_jump} = '0;
    exe_branch_addr = '0; id_jump_addr = '0;
    m_pulse = 0; m_wait = 0; m_pc = '0; m_fif = 0; m_fie = 0; m_sb = 0; m_st = 0;

    idle_s = mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0);
    beq40  = mk(1, 0, 1, 1, 0, 1, 32'h40,  0, 0, 32'h0);
    bne_nt = mk(1, 0, 1, 0, 1, 1, 32'h64,  0, 0, 32'h0);
    j100   = mk(1, 0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h100);
    beq80j = mk(1, 0, 1, 1, 0, 1, 32'h80,  1, 1, 32'h200);
    j200   = mk(1, 0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h200);
    beq44  = mk(1, 0, 1, 1, 0, 1, 32'h44,  0, 0, 32'h0);
    beq44s = mk(1, 1, 1, 1, 0, 1, 32'h44,  0, 0, 32'h0);
    beq84r = mk(0, 0, 1, 1, 0, 1, 32'h84,  0, 0, 32'h0);
    beq48s = mk(1, 1, 1, 1, 0, 1, 32'h48,  0, 0, 32'h0);
    beq48  = mk(1, 0, 1, 1, 0, 1, 32'h48,  0, 0, 32'h0);

    tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0), 0, 32'h0, 0, 0, 0));
    tbl.push_back(row(idle_s, 0, 32'h0,   0, 0, 0));
    // Taken BEQ: one-cycle pulse, busy for two more cycles.
    tbl.push_back(row(beq40,  1, 32'h40,  1, 1, 1));
    tbl.push_back(row(idle_s, 0, 32'h40,  0, 0, 1));
    tbl.push_back(row(idle_s, 0, 32'h40,  0, 0, 1));
    tbl.push_back(row(idle_s, 0, 32'h40,  0, 0, 0));
    // Not-taken BNE then jump.
    tbl.push_back(row(bne_nt, 0, 32'h40,  0, 0, 0));
    tbl.push_back(row(j100,   1, 32'h100, 1, 0, 1));
    tbl.push_back(row(idle_s, 0, 32'h100, 0, 0, 1));
    tbl.push_back(row(idle_s, 0, 32'h100, 0, 0, 0));
    // Branch beats simultaneous jump; wrong-path jump ignored in the shadow.
    tbl.push_back(row(beq80j, 1, 32'h80,  1, 1, 1));
    tbl.push_back(row(j200,   0, 32'h80,  0, 0, 1));
    tbl.push_back(row(j200,   0, 32'h80,  0, 0, 1));
    tbl.push_back(row(j200,   0, 32'h80,  0, 0, 0));
    tbl.push_back(row(idle_s, 0, 32'h80,  0, 0, 0));
    // Stalls inside the shadow stretch busy to 1+2+3 cycles; branches in it are ignored.
    tbl.push_back(row(beq44,  1, 32'h44,  1, 1, 1));
    tbl.push_back(row(beq44s, 0, 32'h44,  0, 0, 1));
    tbl.push_back(row(beq44s, 0, 32'h44,  0, 0, 1));
    tbl.push_back(row(beq44s, 0, 32'h44,  0, 0, 1));
    tbl.push_back(row(beq44s, 0, 32'h44,  0, 0, 1));
    tbl.push_back(row(beq44,  0, 32'h44,  0, 0, 1));
    tbl.push_back(row(beq44,  0, 32'h44,  0, 0, 0));
    tbl.push_back(row(idle_s, 0, 32'h44,  0, 0, 0));
    // Reset on the edge that would start a redirect.
    tbl.push_back(row(beq84r, 0, 32'h0,   0, 0, 0));
    tbl.push_back(row(idle_s, 0, 32'h0,   0, 0, 0));
    // Stall in IDLE defers the decision.
    tbl.push_back(row(beq48s, 0, 32'h0,   0, 0, 0));
    tbl.push_back(row(beq48,  1, 32'h48,  1, 1, 1));

    foreach (tbl[i]) begin
      step(tbl[i].s);
      chk($sformatf("t%0d_redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].rv));
      chk($sformatf("t%0d_redirect_pc", i), redirect_pc, tbl[i].pc);
      chk($sformatf("t%0d_flush_if_id", i), 32'(flush_if_id), 32'(tbl[i].fif));
      chk($sformatf("t%0d_flush_id_exe", i), 32'(flush_id_exe), 32'(tbl[i].fie));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // Continuous taken branches: one accepted every 1+SH+1 cycles, enough to saturate.
    for (int i = 0; i < 80; i++) step(beq48);
`ifdef BRANCH_STATS_EN
    chk("sat_stat_taken", 32'(stat_taken), 32'hF);
    chk("sat_stat_branches", 32'(stat_branches), 32'hF);
`else
    chk("sat_stat_taken", 32'(stat_taken), 32'h0);
    chk("sat_stat_branches", 32'(stat_branches), 32'h0);
`endif

    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
    for (int i = 0; i < 1500; i++) begin
      rs = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, 1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      step(rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
